// File: rtl/packet_input_arbiter_if.sv
// Bundle of per-source packet inputs, their ready back-pressure, and the single
// merged output stream that feeds payload_aligner.
interface packet_input_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int BE_W    = 8
);
  localparam int GW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        iValid;
  logic [NUM_SRC*DATA_W-1:0] iPacket;
  logic [NUM_SRC-1:0]        iSop;
  logic [NUM_SRC-1:0]        iEop;
  logic [NUM_SRC*BE_W-1:0]   iByte_enable;
  logic [NUM_SRC-1:0]        oReady;

  logic                      oValid;
  logic [DATA_W-1:0]         oPacket;
  logic                      oSop;
  logic                      oEop;
  logic [BE_W-1:0]           oByte_enable;
  logic [GW-1:0]             oGrant_id;
  logic                      oAbort;

  // The arbiter side: consumes source beats, drives ready and the merged stream.
  modport master (
    input  iValid, iPacket, iSop, iEop, iByte_enable,
    output oReady, oValid, oPacket, oSop, oEop, oByte_enable, oGrant_id, oAbort
  );

  // The environment side: sources plus the downstream aligner.
  modport slave (
    output iValid, iPacket, iSop, iEop, iByte_enable,
    input  oReady, oValid, oPacket, oSop, oEop, oByte_enable, oGrant_id, oAbort
  );
endinterface

// File: rtl/packet_input_arbiter.sv
// Packet-granular round-robin arbiter: a granted source keeps the stream from sop
// to eop; a stalled packet is force-closed with an abort beat after TIMEOUT idle cycles.
module packet_input_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int BE_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic iClk,
  input  logic iReset,
  packet_input_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt;
  logic [GW-1:0]     rr_ptr, rr_nxt;
  logic [7:0]        idle_cnt, idle_cnt_nxt;
  logic              out_valid, out_valid_nxt;
  logic              out_sop, out_sop_nxt;
  logic              out_eop, out_eop_nxt;
  logic              out_abort, out_abort_nxt;
  logic [DATA_W-1:0] out_data, out_data_nxt;
  logic [BE_W-1:0]   out_be, out_be_nxt;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] cand;
  logic              found;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     after_grant;

  assign cand        = bus.iValid & bus.iSop;
  assign after_grant = (grant == GW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_abort <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      idle_cnt  <= idle_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_sop   <= out_sop_nxt;
      out_eop   <= out_eop_nxt;
      out_abort <= out_abort_nxt;
      out_data  <= out_data_nxt;
      out_be    <= out_be_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_nxt        = rr_ptr;
    idle_cnt_nxt  = idle_cnt;
    out_valid_nxt = 1'b0;
    out_sop_nxt   = 1'b0;
    out_eop_nxt   = 1'b0;
    out_abort_nxt = 1'b0;
    out_data_nxt  = out_data;
    out_be_nxt    = out_be;
    ready         = '0;
    found         = 1'b0;
    winner        = rr_ptr;

    // First sop-bearing source at or after the round-robin pointer wins.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && cand[GW'((int'(rr_ptr) + i) % NUM_SRC)]) begin
        found  = 1'b1;
        winner = GW'((int'(rr_ptr) + i) % NUM_SRC);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = winner;
          state_nxt    = LOCKED;
          idle_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        ready[grant] = 1'b1;
        if (bus.iValid[grant]) begin
          out_valid_nxt = 1'b1;
          out_sop_nxt   = bus.iSop[grant];
          out_eop_nxt   = bus.iEop[grant];
          out_data_nxt  = bus.iPacket[grant*DATA_W +: DATA_W];
          out_be_nxt    = bus.iByte_enable[grant*BE_W +: BE_W];
          idle_cnt_nxt  = '0;
          if (bus.iEop[grant]) begin
            state_nxt = IDLE;
            rr_nxt    = after_grant;
          end
        end else if (idle_cnt + 8'd1 == 8'(TIMEOUT)) begin
          // Close the stalled packet with an empty eop beat so the aligner resynchronises.
          out_valid_nxt = 1'b1;
          out_eop_nxt   = 1'b1;
          out_abort_nxt = 1'b1;
          out_data_nxt  = '0;
          out_be_nxt    = '0;
          idle_cnt_nxt  = '0;
          state_nxt     = IDLE;
          rr_nxt        = after_grant;
        end else begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.oReady       = ready;
  assign bus.oValid       = out_valid;
  assign bus.oPacket      = out_data;
  assign bus.oSop         = out_sop;
  assign bus.oEop         = out_eop;
  assign bus.oByte_enable = out_be;
  assign bus.oGrant_id    = grant;
  assign bus.oAbort       = out_abort;
endmodule

// File: tb/tb_packet_input_arbiter.sv
// Directed bench for packet_input_arbiter: a per-cycle vector table with
// hand-computed ready/output expectations, plus a timeout-latency sequence.
module tb_packet_input_arbiter;
  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  packet_input_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .BE_W(BE_W)) bus();

  packet_input_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .BE_W(BE_W), .TIMEOUT(TIMEOUT)) dut (
    .iClk   (clk),
    .iReset (rst_n),
    .bus    (bus)
  );

  // One clock cycle: inputs held during the cycle, ready expected during it,
  // registered outputs expected just after its rising edge.
  typedef struct {
    logic       rst_n;
    logic [3:0] valid, sop, eop;
    logic [7:0] dat, be;
    logic [3:0] rdy;
    logic       ov, osop, oeop, oab;
    logic [1:0] gr;
    logic [7:0] esrc, edat, ebe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] va, sp, ep, input logic [7:0] d, b,
                     input logic [3:0] rd, input logic ov, os, oe, oa, input logic [1:0] g,
                     input logic [7:0] es, ed, eb);
    vec_t v;
    v = '{r, va, sp, ep, d, b, rd, ov, os, oe, oa, g, es, ed, eb};
    vecs.push_back(v);
  endtask

  // Source k carries its own index in the top byte so a leak from a wrong source shows.
  task automatic applyStimulus(input vec_t v);
    rst_n            = v.rst_n;
    bus.iValid       = v.valid;
    bus.iSop         = v.sop;
    bus.iEop         = v.eop;
    for (int k = 0; k < NUM_SRC; k++) begin
      bus.iPacket[k*DATA_W +: DATA_W]    = {8'(k), 48'h0, v.dat};
      bus.iByte_enable[k*BE_W +: BE_W]   = v.be;
    end
  endtask

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [79:0] pack_out(input logic ov, sop, eop, ab, input logic [1:0] gr,
                                           input logic [63:0] data, input logic [7:0] be,
                                           input logic full);
    return {2'b00, ov, full ? sop : 1'b0, full ? eop : 1'b0, ab, gr,
            full ? data : 64'h0, full ? be : 8'h0};
  endfunction

  function automatic logic [79:0] dut_out(input logic full);
    return pack_out(bus.oValid, bus.oSop, bus.oEop, bus.oAbort, bus.oGrant_id,
                    bus.oPacket, bus.oByte_enable, full);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t idle_v;
    int   n;
    logic full;

    // single source, 3-beat packet
    add(1,4'b0001,4'b0001,4'b0000,8'hA0,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0001,4'b0001,4'b0000,8'hA0,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'hA0,8'hFF);
    add(1,4'b0001,4'b0000,4'b0000,8'hA1,8'hFF, 4'b0001, 1,0,0,0,2'd0, 8'd0,8'hA1,8'hFF);
    add(1,4'b0001,4'b0000,4'b0001,8'hA2,8'hFF, 4'b0001, 1,0,1,0,2'd0, 8'd0,8'hA2,8'hFF);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'h00, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    // reset to bring the pointer back to 0, then all four contend
    add(0,4'b0000,4'b0000,4'b0000,8'h00,8'h00, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'hB0,8'hFF);
    add(1,4'b1111,4'b1110,4'b0001,8'hB1,8'hFF, 4'b0001, 1,0,1,0,2'd0, 8'd0,8'hB1,8'hFF);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0000, 0,0,0,0,2'd1, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0010, 1,1,0,0,2'd1, 8'd1,8'hB0,8'hFF);
    add(1,4'b1111,4'b1101,4'b0010,8'hB1,8'hFF, 4'b0010, 1,0,1,0,2'd1, 8'd1,8'hB1,8'hFF);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0000, 0,0,0,0,2'd2, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0100, 1,1,0,0,2'd2, 8'd2,8'hB0,8'hFF);
    add(1,4'b1111,4'b1011,4'b0100,8'hB1,8'hFF, 4'b0100, 1,0,1,0,2'd2, 8'd2,8'hB1,8'hFF);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0000, 0,0,0,0,2'd3, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b1000, 1,1,0,0,2'd3, 8'd3,8'hB0,8'hFF);
    add(1,4'b1111,4'b0111,4'b1000,8'hB1,8'hFF, 4'b1000, 1,0,1,0,2'd3, 8'd3,8'hB1,8'hFF);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b1111,4'b1111,4'b0000,8'hB0,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'hB0,8'hFF);
    add(1,4'b1111,4'b1110,4'b0001,8'hB1,8'hFF, 4'b0001, 1,0,1,0,2'd0, 8'd0,8'hB1,8'hFF);
    // src1 granted, src2 raises sop mid-packet and must wait
    add(1,4'b0010,4'b0010,4'b0000,8'hC0,8'hFF, 4'b0000, 0,0,0,0,2'd1, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hC0,8'hFF, 4'b0010, 1,1,0,0,2'd1, 8'd1,8'hC0,8'hFF);
    add(1,4'b0110,4'b0100,4'b0000,8'hC1,8'hFF, 4'b0010, 1,0,0,0,2'd1, 8'd1,8'hC1,8'hFF);
    add(1,4'b0110,4'b0100,4'b0010,8'hC2,8'hFF, 4'b0010, 1,0,1,0,2'd1, 8'd1,8'hC2,8'hFF);
    add(1,4'b0100,4'b0100,4'b0000,8'hD0,8'hFF, 4'b0000, 0,0,0,0,2'd2, 8'd0,8'h00,8'h00);
    add(1,4'b0100,4'b0100,4'b0000,8'hD0,8'hFF, 4'b0100, 1,1,0,0,2'd2, 8'd2,8'hD0,8'hFF);
    add(1,4'b0100,4'b0000,4'b0100,8'hD1,8'hFF, 4'b0100, 1,0,1,0,2'd2, 8'd2,8'hD1,8'hFF);
    // single-beat packet from src3, pointer wraps so src0 beats src1 next
    add(1,4'b1000,4'b1000,4'b1000,8'h55,8'h0F, 4'b0000, 0,0,0,0,2'd3, 8'd0,8'h00,8'h00);
    add(1,4'b1000,4'b1000,4'b1000,8'h55,8'h0F, 4'b1000, 1,1,1,0,2'd3, 8'd3,8'h55,8'h0F);
    add(1,4'b0011,4'b0011,4'b0011,8'h66,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0011,4'b0011,4'b0011,8'h66,8'hFF, 4'b0001, 1,1,1,0,2'd0, 8'd0,8'h66,8'hFF);
    // timeout abort with src1 waiting
    add(1,4'b0001,4'b0001,4'b0000,8'hE0,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0001,4'b0001,4'b0000,8'hE0,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'hE0,8'hFF);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0001, 1,0,1,1,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0000, 0,0,0,0,2'd1, 8'd0,8'h00,8'h00);
    add(1,4'b0010,4'b0010,4'b0000,8'hF0,8'hFF, 4'b0010, 1,1,0,0,2'd1, 8'd1,8'hF0,8'hFF);
    add(1,4'b0010,4'b0000,4'b0010,8'hF1,8'hFF, 4'b0010, 1,0,1,0,2'd1, 8'd1,8'hF1,8'hFF);
    // valid returns on the cycle the counter would reach TIMEOUT: no abort
    add(1,4'b0001,4'b0001,4'b0000,8'hE0,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0001,4'b0001,4'b0000,8'hE0,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'hE0,8'hFF);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0001,4'b0000,4'b0001,8'hE1,8'hFF, 4'b0001, 1,0,1,0,2'd0, 8'd0,8'hE1,8'hFF);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'h00, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    // reset during beat 2 of a longer packet, then src2 granted normally
    add(1,4'b0001,4'b0001,4'b0000,8'h10,8'hFF, 4'b0000, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0001,4'b0001,4'b0000,8'h10,8'hFF, 4'b0001, 1,1,0,0,2'd0, 8'd0,8'h10,8'hFF);
    add(1,4'b0001,4'b0000,4'b0000,8'h11,8'hFF, 4'b0001, 1,0,0,0,2'd0, 8'd0,8'h11,8'hFF);
    add(0,4'b0001,4'b0000,4'b0000,8'h12,8'hFF, 4'b0001, 0,0,0,0,2'd0, 8'd0,8'h00,8'h00);
    add(1,4'b0100,4'b0100,4'b0000,8'h20,8'hFF, 4'b0000, 0,0,0,0,2'd2, 8'd0,8'h00,8'h00);
    add(1,4'b0100,4'b0100,4'b0000,8'h20,8'hFF, 4'b0100, 1,1,0,0,2'd2, 8'd2,8'h20,8'hFF);
    add(1,4'b0100,4'b0000,4'b0100,8'h21,8'hFF, 4'b0100, 1,0,1,0,2'd2, 8'd2,8'h21,8'hFF);
    add(1,4'b0000,4'b0000,4'b0000,8'h00,8'h00, 4'b0000, 0,0,0,0,2'd2, 8'd0,8'h00,8'h00);

    $display("[TB] start, %0d vectors", vecs.size());

    idle_v = '{1'b0, 4'h0, 4'h0, 4'h0, 8'h0, 8'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0, 8'h0, 8'h0};
    applyStimulus(idle_v);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 80'(bus.oReady), 80'h0);
    checkOutput("reset_out", dut_out(1'b1), pack_out(0,0,0,0,2'd0,64'h0,8'h0,1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_ready", i), 80'(bus.oReady), 80'(vecs[i].rdy));
      @(posedge clk);
      #1;
      full = vecs[i].ov || !vecs[i].rst_n;
      checkOutput($sformatf("v%0d_out", i), dut_out(full),
                  pack_out(vecs[i].ov, vecs[i].osop, vecs[i].oeop, vecs[i].oab, vecs[i].gr,
                           {vecs[i].esrc, 48'h0, vecs[i].edat}, vecs[i].ebe, full));
    end

    // src1 sends only a sop beat; abort must land exactly TIMEOUT cycles after it stalls
    @(negedge clk);
    idle_v.rst_n = 1'b1;
    idle_v.valid = 4'b0010;
    idle_v.sop   = 4'b0010;
    idle_v.dat   = 8'h30;
    idle_v.be    = 8'hFF;
    applyStimulus(idle_v);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall_first_beat", dut_out(1'b1),
                pack_out(1,1,0,0,2'd1,{8'd1,48'h0,8'h30},8'hFF,1'b1));
    @(negedge clk);
    idle_v.valid = 4'b0000;
    idle_v.sop   = 4'b0000;
    applyStimulus(idle_v);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.oAbort) break;
    end
    checkOutput("abort_latency", 80'(n), 80'(TIMEOUT));
    checkOutput("abort_beat", dut_out(1'b1), pack_out(1,0,1,1,2'd1,64'h0,8'h0,1'b1));
    @(posedge clk);
    #1;
    checkOutput("abort_pulse_end", {78'h0, bus.oAbort, bus.oValid}, 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
